// File: rtl/timer_setter_if.sv
// rtl/timer_setter_if.sv - keypad and counter-chain signal bundle for timer_setter
interface timer_setter_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic       zero_all;
  logic [3:0] data_min_tens;
  logic [3:0] data_min_ones;
  logic [2:0] data_sec_tens;
  logic [3:0] data_sec_ones;
  logic       loadn;
  logic       clearn;
  logic       en;
  logic       done;
  logic       err;

  // Setter side: consumes keys and terminal count, drives the counter chain.
  modport slave (
    input  key_valid, key_code, zero_all,
    output data_min_tens, data_min_ones, data_sec_tens, data_sec_ones,
    output loadn, clearn, en, done, err
  );

  // Environment side: keypad decoder plus counter chain.
  modport master (
    output key_valid, key_code, zero_all,
    input  data_min_tens, data_min_ones, data_sec_tens, data_sec_ones,
    input  loadn, clearn, en, done, err
  );
endinterface

// File: rtl/timer_setter.sv
// rtl/timer_setter.sv - keypad MM:SS entry and countdown control; optional macro TIMER_SETTER_TIMEOUT_EN adds an idle-entry timeout
module timer_setter #(
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input logic           clk,
  input logic           clear,
  timer_setter_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ENTRY, LOAD, RUN, PAUSE} state_t;

  state_t      state;
  logic [15:0] buffer;
  logic        loadn_q;
  logic        clearn_q;
  logic        en_q;
  logic        done_q;
  logic        err_q;

  logic is_digit;
  logic is_start;
  logic is_cancel;

  assign is_digit  = bus.key_valid && (bus.key_code <= 4'd9);
  assign is_start  = bus.key_valid && (bus.key_code == 4'hA);
  assign is_cancel = bus.key_valid && (bus.key_code == 4'hB);

  assign bus.data_min_tens = buffer[15:12];
  assign bus.data_min_ones = buffer[11:8];
  assign bus.data_sec_tens = buffer[6:4];
  assign bus.data_sec_ones = buffer[3:0];
  assign bus.loadn         = loadn_q;
  assign bus.clearn        = clearn_q;
  assign bus.en            = en_q;
  assign bus.done          = done_q;
  assign bus.err           = err_q;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

`ifdef TIMER_SETTER_TIMEOUT_EN
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] idle_cnt;
`endif

  // Control FSM: digit buffer, state and registered strobes to the counter chain.
  always_ff @(posedge clk) begin
    if (clear) begin
      state    <= IDLE;
      buffer   <= 16'h0000;
      loadn_q  <= 1'b1;
      clearn_q <= 1'b1;
      en_q     <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef TIMER_SETTER_TIMEOUT_EN
      idle_cnt <= 32'd0;
`endif
    end else begin
      loadn_q  <= 1'b1;
      clearn_q <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      if (is_cancel) begin
        state    <= IDLE;
        buffer   <= 16'h0000;
        clearn_q <= 1'b0;
        en_q     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (is_digit) begin
              buffer <= {buffer[11:0], bus.key_code};
              state  <= ENTRY;
`ifdef TIMER_SETTER_TIMEOUT_EN
              idle_cnt <= 32'd0;
`endif
            end
          end
          ENTRY: begin
            if (is_digit) begin
              buffer <= {buffer[11:0], bus.key_code};
            end else if (is_start) begin
              // Seconds-tens above 5 is a bad entry; an all-zero buffer is silently ignored.
              if (buffer[7:4] > 4'd5) begin
                err_q <= 1'b1;
              end else if (buffer != 16'h0000) begin
                state   <= LOAD;
                loadn_q <= 1'b0;
              end
            end
`ifdef TIMER_SETTER_TIMEOUT_EN
            if (is_digit || is_start) begin
              idle_cnt <= 32'd0;
            end else if (idle_cnt == TIMEOUT_LAST) begin
              state    <= IDLE;
              buffer   <= 16'h0000;
              idle_cnt <= 32'd0;
            end else begin
              idle_cnt <= idle_cnt + 32'd1;
            end
`endif
          end
          LOAD: begin
            state <= RUN;
            en_q  <= 1'b1;
          end
          RUN: begin
            if (bus.zero_all) begin
              state  <= IDLE;
              buffer <= 16'h0000;
              done_q <= 1'b1;
              en_q   <= 1'b0;
            end else if (is_start) begin
              state <= PAUSE;
              en_q  <= 1'b0;
            end
          end
          PAUSE: begin
            if (is_start) begin
              state <= RUN;
              en_q  <= 1'b1;
            end
          end
          default: begin
            state  <= IDLE;
            buffer <= 16'h0000;
            en_q   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
